// File: rtl/prim_pkg.sv
// Shared types for the primitive decoder/encoder family: decoded entry layout,
// skid-buffer state encoding and the fixed decoded-vector width.
package prim_pkg;

   localparam int DEC_OUT_W = 16;

   typedef struct packed {
      logic [DEC_OUT_W-1:0] onehot;
      logic [3:0]           idx;
   } dec_entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/prim_decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module prim_decoder_3to8 (
   input  logic [2:0] i_bin,
   input  logic       i_en,
   output logic [7:0] o_dec
);

   assign o_dec = i_en ? (8'd1 << i_bin) : 8'd0;

endmodule

// File: rtl/prim_decoder_4to16.sv
// Combinational 4-to-16 one-hot decoder built from two 3-to-8 halves; the
// top index bit selects which half is enabled.
module prim_decoder_4to16
   import prim_pkg::*;
(
   input  logic [3:0]           i_bin,
   input  logic                 i_en,
   output logic [DEC_OUT_W-1:0] o_dec
);

   logic en_lo;
   logic en_hi;

   assign en_lo = i_en & ~i_bin[3];
   assign en_hi = i_en &  i_bin[3];

   prim_decoder_3to8 u_dec_lo (
      .i_bin (i_bin[2:0]),
      .i_en  (en_lo),
      .o_dec (o_dec[7:0])
   );

   prim_decoder_3to8 u_dec_hi (
      .i_bin (i_bin[2:0]),
      .i_en  (en_hi),
      .o_dec (o_dec[15:8])
   );

endmodule

// File: rtl/prim_decoder_4to16_pipe.sv
// Registered 4-to-16 one-hot decoder with valid/ready on both sides and a
// 2-entry skid stage. Optional sticky delivered-vector mask: PRIM_DEC_STICKY_EN.
module prim_decoder_4to16_pipe
   import prim_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_vld,
   output logic                   o_rdy,
   input  logic [ADDR_W-1:0]      i_idx,
   input  logic                   i_en,
   output logic                   o_vld,
   input  logic                   i_rdy,
   output logic [2**ADDR_W-1:0]   o_onehot,
   output logic [ADDR_W-1:0]      o_idx,
   input  logic                   i_clr,
   output logic [2**ADDR_W-1:0]   o_mask
);

   localparam int OUT_W = 2**ADDR_W;

   localparam logic [1:0] ST_EMPTY = EMPTY;
   localparam logic [1:0] ST_ONE   = ONE;
   localparam logic [1:0] ST_FULL  = FULL;

   logic [DEC_OUT_W-1:0] dec_p0;
   dec_entry_t           entry_p0;

   logic [1:0]  state_p1;
   logic [1:0]  state_nxt;
   logic        vld_p1;
   logic        rdy_p1;
   dec_entry_t  out_p1;
   dec_entry_t  skid_p1;

   logic in_xfer;
   logic out_xfer;
   logic load_out;
   logic load_skid;
   logic skid_to_out;

   // Stage 0: decode at the input so every captured vector is already one-hot
   prim_decoder_4to16 u_dec (
      .i_bin (i_idx),
      .i_en  (i_en),
      .o_dec (dec_p0)
   );

   assign entry_p0 = '{onehot: dec_p0, idx: i_idx};

   assign in_xfer  = i_vld & rdy_p1;
   assign out_xfer = vld_p1 & i_rdy;

   always_comb begin
      state_nxt   = state_p1;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state_p1)
         ST_EMPTY: begin
            if (in_xfer) begin
               load_out  = 1'b1;
               state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               load_out = 1'b1;
            end else if (out_xfer) begin
               state_nxt = ST_EMPTY;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               skid_to_out = 1'b1;
               state_nxt   = ST_ONE;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // Stage 1: output and skid registers; ready is registered from the next state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_p1 <= ST_EMPTY;
         vld_p1   <= 1'b0;
         rdy_p1   <= 1'b1;
         out_p1   <= '0;
      end else begin
         state_p1 <= state_nxt;
         vld_p1   <= (state_nxt != ST_EMPTY);
         rdy_p1   <= (state_nxt != ST_FULL);
         if (load_out) begin
            out_p1 <= entry_p0;
         end else if (skid_to_out) begin
            out_p1 <= skid_p1;
         end
      end
   end

   // The skid entry is only ever read after being written, so it needs no reset
   always_ff @(posedge i_clk) begin
      if (load_skid) begin
         skid_p1 <= entry_p0;
      end
   end

   assign o_vld    = vld_p1;
   assign o_rdy    = rdy_p1;
   assign o_onehot = out_p1.onehot;
   assign o_idx    = out_p1.idx;

`ifdef PRIM_DEC_STICKY_EN
   logic [OUT_W-1:0] mask_p2;

   // Stage 2: clear wins over accumulation but still keeps a same-cycle delivery
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mask_p2 <= '0;
      end else if (i_clr) begin
         mask_p2 <= out_xfer ? out_p1.onehot : '0;
      end else if (out_xfer) begin
         mask_p2 <= mask_p2 | out_p1.onehot;
      end
   end

   assign o_mask = mask_p2;
`else
   logic unused_clr;

   assign unused_clr = i_clr;
   assign o_mask     = {OUT_W{1'b0}};
`endif

endmodule
